// File: rtl/irq_fifo_mc_pkg.sv
// rtl/irq_fifo_mc_pkg.sv - shared constants, response kinds and sizing helper for irq_fifo_mc
package irq_fifo_mc_pkg;

    localparam logic [10:0] STATUS_ADDR     = 11'h7FF;
    localparam int          RDATA_VALID_BIT = 31;
    localparam int          RDATA_OVF_BIT   = 30;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_POP,
        RESP_STATUS,
        RESP_ERR
    } resp_kind_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
    parameter int W = 14,
    parameter int A = 5
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [A-1:0] raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [2**A];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/irq_fifo_mc.sv
// rtl/irq_fifo_mc.sv - multi-channel interrupt FIFO popped over the config bus
// Optional: IRQ_FIFO_MC_DROP_EN (never stall producers; drops set sticky per-queue ovf)
module irq_fifo_mc
    import irq_fifo_mc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 14
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [13:0]              config_addr,
    input  logic                     config_en,
    input  logic                     config_wr,
    input  logic [31:0]              config_wdata,
    input  logic                     sel,
    output logic [31:0]              config_slv_rdata,
    output logic                     config_slv_error,
    input  logic [NUM_CH-1:0]        wr_valid,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0]        wr_ready,
    output logic [NUM_CH-1:0]        irq_sig
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int RA = clog2(NUM_CH * DEPTH);

    typedef logic [PW-1:0] ptr_t;

    ptr_t w_ptr   [NUM_CH];
    ptr_t r_ptr   [NUM_CH];
    ptr_t w_ptr_n [NUM_CH];
    ptr_t r_ptr_n [NUM_CH];

    logic [NUM_CH-1:0] empty, full, empty_n, grant, irq_q, ovf, ovf_n;
    logic              ram_we;
    logic [RA-1:0]     ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_q;

    logic              acc, acc_pop, acc_status, pop_hit;
    logic [CW-1:0]     pop_c;
    resp_kind_t        resp_kind;
    logic              resp_ovf;
    logic [NUM_CH-1:0] resp_map;
    logic              unused_bits;

    assign unused_bits = ^{config_wdata, config_addr[13:11]};

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c] = (w_ptr[c] == r_ptr[c]);
            full[c]  = (w_ptr[c][AW-1:0] == r_ptr[c][AW-1:0]) && (w_ptr[c][PW-1] != r_ptr[c][PW-1]);
        end
    end

    // Single write port: lowest-index non-full requester wins.
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!found && wr_valid[c] && !full[c]) begin
                grant[c] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign acc        = sel & config_en;
    assign acc_status = acc & !config_wr & (config_addr[10:0] == STATUS_ADDR);
    assign acc_pop    = acc & !config_wr & (config_addr[10:0] < 11'(NUM_CH));
    assign pop_c      = config_addr[CW-1:0];
    assign pop_hit    = acc_pop & !empty[pop_c];

`ifdef IRQ_FIFO_MC_DROP_EN
    assign wr_ready = '1;

    // Clear-on-pop comes first so a drop in the same cycle wins.
    always_comb begin
        ovf_n = ovf;
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc_pop && pop_c == CW'(c)) ovf_n[c] = 1'b0;
            if (wr_valid[c] && !grant[c])   ovf_n[c] = 1'b1;
        end
    end
`else
    assign wr_ready = grant;
    assign ovf_n    = '0;
`endif

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_ptr_n[c] = w_ptr[c] + ptr_t'(grant[c]);
            r_ptr_n[c] = r_ptr[c] + ptr_t'(pop_hit && pop_c == CW'(c));
            empty_n[c] = (w_ptr_n[c] == r_ptr_n[c]);
        end
    end

    always_comb begin
        ram_we    = |grant;
        ram_wdata = '0;
        ram_waddr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                ram_wdata = wr_data[c*DATA_W +: DATA_W];
                ram_waddr = RA'(c * DEPTH) + RA'(w_ptr[c][AW-1:0]);
            end
        end
    end

    assign ram_raddr = RA'(int'(pop_c) * DEPTH) + RA'(r_ptr[pop_c][AW-1:0]);

    sdp_ram #(
        .W (DATA_W),
        .A (RA)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (pop_hit),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_ptr[c] <= '0;
                r_ptr[c] <= '0;
            end
            irq_q     <= '0;
            ovf       <= '0;
            resp_kind <= RESP_NONE;
            resp_ovf  <= 1'b0;
            resp_map  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_ptr[c] <= w_ptr_n[c];
                r_ptr[c] <= r_ptr_n[c];
            end
            // Registered from next-state pointers: same timing as !empty, no decode glitches.
            irq_q <= ~empty_n;
            ovf   <= ovf_n;
            if (acc) begin
                resp_ovf <= 1'b0;
                if (acc_pop) begin
                    resp_kind <= pop_hit ? RESP_POP : RESP_NONE;
                    resp_ovf  <= ovf[pop_c];
                end else if (acc_status) begin
                    resp_kind <= RESP_STATUS;
                    resp_map  <= ~empty;
                end else begin
                    resp_kind <= RESP_ERR;
                end
            end
        end
    end

    assign irq_sig = irq_q;

    always_comb begin
        config_slv_rdata = '0;
        case (resp_kind)
            RESP_POP: begin
                config_slv_rdata[DATA_W-1:0]     = ram_q;
                config_slv_rdata[RDATA_VALID_BIT] = 1'b1;
                config_slv_rdata[RDATA_OVF_BIT]   = resp_ovf;
            end
            RESP_NONE:   config_slv_rdata[RDATA_OVF_BIT] = resp_ovf;
            RESP_STATUS: config_slv_rdata[NUM_CH-1:0]    = resp_map;
            default:     config_slv_rdata = '0;
        endcase
    end

    assign config_slv_error = (resp_kind == RESP_ERR);

endmodule

// File: tb/tb_irq_fifo_mc.sv
// tb/tb_irq_fifo_mc.sv - directed self-checking bench for irq_fifo_mc
module tb_irq_fifo_mc;

    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 14;

`ifdef IRQ_FIFO_MC_DROP_EN
    localparam logic [31:0] Q1_OVF = 32'h4000_0000;
`else
    localparam logic [31:0] Q1_OVF = 32'h0000_0000;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [13:0]              config_addr = '0;
    logic                     config_en = 1'b0;
    logic                     config_wr = 1'b0;
    logic [31:0]              config_wdata = '0;
    logic                     sel = 1'b0;
    logic [31:0]              config_slv_rdata;
    logic                     config_slv_error;
    logic [NUM_CH-1:0]        wr_valid = '0;
    logic [NUM_CH*DATA_W-1:0] wr_data = '0;
    logic [NUM_CH-1:0]        wr_ready;
    logic [NUM_CH-1:0]        irq_sig;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] rd;
    logic [31:0] exp_q [$];

    irq_fifo_mc #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .config_addr      (config_addr),
        .config_en        (config_en),
        .config_wr        (config_wr),
        .config_wdata     (config_wdata),
        .sel              (sel),
        .config_slv_rdata (config_slv_rdata),
        .config_slv_error (config_slv_error),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .irq_sig          (irq_sig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic push(input int ch, input logic [DATA_W-1:0] d);
        bit done;
        done = 1'b0;
        wr_valid[ch] = 1'b1;
        wr_data[ch*DATA_W +: DATA_W] = d;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (wr_ready[ch]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        wr_valid[ch] = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic cfg(input logic wr, input logic [13:0] a, output logic [31:0] data);
        sel         = 1'b1;
        config_en   = 1'b1;
        config_wr   = wr;
        config_addr = a;
        @(posedge clk);
        #1;
        sel       = 1'b0;
        config_en = 1'b0;
        config_wr = 1'b0;
        data      = config_slv_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, then reset asserted mid-push and mid-pop
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", 32'(irq_sig), 32'h0);
        check("rst_rdata", config_slv_rdata, 32'h0);
        check("rst_err", 32'(config_slv_error), 32'h0);
        reset_n = 1'b1;
        push(0, 14'h011);
        check("pre_rst_irq", 32'(irq_sig), 32'h1);
        wr_valid[1] = 1'b1;
        wr_data[DATA_W +: DATA_W] = 14'h022;
        sel = 1'b1; config_en = 1'b1; config_addr = 14'd0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_irq", 32'(irq_sig), 32'h0);
        check("midrst_rdata", config_slv_rdata, 32'h0);
        wr_valid = '0; sel = 1'b0; config_en = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cfg(1'b0, 14'h7FF, rd);
        check("post_rst_status", rd, 32'h0);
        cfg(1'b0, 14'd0, rd);
        check("post_rst_pop0", rd, 32'h0);

        // 2: two pushes then three pops on q0
        push(0, 14'h0A1);
        push(0, 14'h0A2);
        check("t2_irq_up", 32'(irq_sig), 32'h1);
        cfg(1'b0, 14'd0, rd);
        check("t2_pop1", rd, 32'h800000A1);
        check("t2_irq_mid", 32'(irq_sig), 32'h1);
        cfg(1'b0, 14'd0, rd);
        check("t2_pop2", rd, 32'h800000A2);
        check("t2_irq_fall", 32'(irq_sig), 32'h0);
        cfg(1'b0, 14'd0, rd);
        check("t2_pop3", rd, 32'h0);
        check("t2_err", 32'(config_slv_error), 32'h0);

`ifndef IRQ_FIFO_MC_DROP_EN
        // 3: fill q1, refuse 17th, pop+push together, wrap through 40 entries
        for (int i = 0; i < DEPTH; i++) begin
            push(1, 14'(32'h100 + i));
            exp_q.push_back(32'h100 + i);
        end
        check("t3_irq_full", 32'(irq_sig), 32'h2);
        wr_valid[1] = 1'b1;
        wr_data[DATA_W +: DATA_W] = 14'h110;
        #1;
        check("t3_ready_full", 32'(wr_ready), 32'h0);
        sel = 1'b1; config_en = 1'b1; config_wr = 1'b0; config_addr = 14'd1;
        #1;
        check("t3_ready_popcyc", 32'(wr_ready), 32'h0);
        @(posedge clk);
        #1;
        check("t3_pop_full", config_slv_rdata, 32'h80000000 | exp_q.pop_front());
        check("t3_ready_after", 32'(wr_ready), 32'h2);
        for (int j = 0; j < 24; j++) begin
            wr_data[DATA_W +: DATA_W] = 14'(32'h110 + j);
            @(posedge clk);
            #1;
            exp_q.push_back(32'h110 + j);
            check("t3_stream", config_slv_rdata, 32'h80000000 | exp_q.pop_front());
        end
        wr_valid = '0;
        sel = 1'b0; config_en = 1'b0;
        while (exp_q.size() > 0) begin
            cfg(1'b0, 14'd1, rd);
            check("t3_drain", rd, 32'h80000000 | exp_q.pop_front());
        end
        cfg(1'b0, 14'd1, rd);
        check("t3_empty", rd, 32'h0);
        check("t3_irq_end", 32'(irq_sig), 32'h0);
`endif

        // 4: simultaneous producers
        wr_valid = 2'b11;
        wr_data  = {14'h1B0, 14'h0B0};
        #1;
`ifdef IRQ_FIFO_MC_DROP_EN
        check("t4_ready_both", 32'(wr_ready), 32'h3);
`else
        check("t4_ready_both", 32'(wr_ready), 32'h1);
`endif
        @(posedge clk);
        #1;
        wr_valid[0] = 1'b0;
        #1;
`ifdef IRQ_FIFO_MC_DROP_EN
        check("t4_ready_q1", 32'(wr_ready), 32'h3);
`else
        check("t4_ready_q1", 32'(wr_ready), 32'h2);
`endif
        @(posedge clk);
        #1;
        wr_valid = '0;
        cfg(1'b0, 14'h7FF, rd);
        check("t4_status", rd, 32'h3);
        cfg(1'b0, 14'd0, rd);
        check("t4_pop0", rd, 32'h800000B0);
        cfg(1'b0, 14'd1, rd);
        check("t4_pop1", rd, 32'h800001B0 | Q1_OVF);
        cfg(1'b0, 14'h7FF, rd);
        check("t4_status_end", rd, 32'h0);

        // 5: error responses
        push(0, 14'h0C3);
        cfg(1'b1, 14'd0, rd);
        check("t5_wr_rdata", rd, 32'h0);
        check("t5_wr_err", 32'(config_slv_error), 32'h1);
        cfg(1'b0, 14'd5, rd);
        check("t5_unmap_rdata", rd, 32'h0);
        check("t5_unmap_err", 32'(config_slv_error), 32'h1);
        @(posedge clk);
        #1;
        check("t5_err_hold", 32'(config_slv_error), 32'h1);
        cfg(1'b0, 14'd0, rd);
        check("t5_pop", rd, 32'h800000C3);
        check("t5_err_clr", 32'(config_slv_error), 32'h0);

`ifdef IRQ_FIFO_MC_DROP_EN
        // 6: overflow on full queue
        for (int i = 0; i < DEPTH; i++) push(0, 14'(32'h200 + i));
        push(0, 14'h2FF);
        cfg(1'b0, 14'd0, rd);
        check("t6_pop_ovf", rd, 32'hC0000200);
        cfg(1'b0, 14'd0, rd);
        check("t6_pop_clr", rd, 32'h80000201);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
